// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/split/stop control FSM with lap counter and split-view freeze.
// Optional split hold timeout is enabled by defining STOPWATCH_SPLIT_TIMEOUT_EN.
module stopwatch_ctrl #(
    parameter int SPLIT_HOLD_MS = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic        start_p,
    input  logic        stop_p,
    input  logic        split_p,
    input  logic [31:0] time_in,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic [31:0] disp_time,
    output logic        frozen,
    output logic [3:0]  lap_cnt,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, SPLIT = 2'b10, STOPPED = 2'b11} state_t;
    state_t      r_state;
    state_t      w_next;
    logic        r_cnt_en;
    logic        r_cnt_clr;
    logic [3:0]  r_lap;
    logic [31:0] r_split;
    logic        w_latch;
    logic        w_clr;
    logic        w_expire;
`ifdef STOPWATCH_SPLIT_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(SPLIT_HOLD_MS - 1);
    logic [15:0] r_timer;
    always_ff @(posedge clk) begin
        if (rst)
            r_timer <= 16'd0;
        else if (w_latch)
            r_timer <= 16'd0;
        else if (r_state == SPLIT && tick_ms)
            r_timer <= r_timer + 16'd1;
    end
    assign w_expire = (r_state == SPLIT) && tick_ms && (r_timer == HOLD_LAST);
`else
    logic w_unused;
    assign w_unused = tick_ms | (SPLIT_HOLD_MS == 0);
    assign w_expire = 1'b0;
`endif
    // stop outranks split outranks start; events not valid in a state are dropped
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_clr   = 1'b0;
        case (r_state)
            IDLE:    if (start_p) w_next = RUNNING;
            RUNNING: if (stop_p) w_next = STOPPED;
                     else if (split_p) begin
                         w_next  = SPLIT;
                         w_latch = 1'b1;
                     end
            SPLIT:   if (stop_p) w_next = STOPPED;
                     else if (split_p || w_expire) w_next = RUNNING;
            STOPPED: if (split_p) begin
                         w_next = IDLE;
                         w_clr  = 1'b1;
                     end
                     else if (start_p) w_next = RUNNING;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_lap     <= 4'd0;
            r_split   <= 32'd0;
        end else begin
            r_state   <= w_next;
            r_cnt_en  <= (w_next == RUNNING) || (w_next == SPLIT);
            r_cnt_clr <= w_clr;
            if (w_latch) begin
                r_split <= time_in;
                r_lap   <= (r_lap == 4'd9) ? 4'd0 : r_lap + 4'd1;
            end else if (w_clr)
                r_lap <= 4'd0;
        end
    end
    assign cnt_en    = r_cnt_en;
    assign cnt_clr   = r_cnt_clr;
    assign lap_cnt   = r_lap;
    assign state     = r_state;
    assign frozen    = (r_state == SPLIT);
    assign disp_time = (r_state == SPLIT && !rst) ? r_split : time_in;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and randomized checks of stopwatch_ctrl against a behavioural model.
module tb_stopwatch_ctrl;
    localparam int HOLD = 5;
`ifdef STOPWATCH_SPLIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_ms = 1'b0;
    logic        start_p = 1'b0;
    logic        stop_p = 1'b0;
    logic        split_p = 1'b0;
    logic [31:0] time_in = 32'd0;
    logic        cnt_en;
    logic        cnt_clr;
    logic [31:0] disp_time;
    logic        frozen;
    logic [3:0]  lap_cnt;
    logic [1:0]  state;
    int total = 0;
    int bad = 0;
    int          m_state = 0;
    int          m_lap = 0;
    int          m_ticks = 0;
    bit          m_clr = 0;
    logic [31:0] m_split = 32'd0;

    stopwatch_ctrl #(.SPLIT_HOLD_MS(HOLD)) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .start_p(start_p), .stop_p(stop_p),
        .split_p(split_p), .time_in(time_in), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .disp_time(disp_time), .frozen(frozen), .lap_cnt(lap_cnt), .state(state)
    );

    always #5 clk = ~clk;

    // 0=IDLE 1=RUNNING 2=SPLIT 3=STOPPED
    task automatic model(input logic r, st, sp, sl, tk, input logic [31:0] t);
        m_clr = 0;
        if (r) begin
            m_state = 0; m_lap = 0; m_split = 32'd0; m_ticks = 0;
            return;
        end
        case (m_state)
            0: if (st) m_state = 1;
            1: if (sp) m_state = 3;
               else if (sl) begin
                   m_state = 2; m_split = t; m_lap = (m_lap + 1) % 10; m_ticks = 0;
               end
            2: if (sp) m_state = 3;
               else if (sl) m_state = 1;
               else if (TO_EN && tk) begin
                   m_ticks++;
                   if (m_ticks >= HOLD) m_state = 1;
               end
            3: if (sl) begin
                   m_state = 0; m_clr = 1; m_lap = 0;
               end else if (st) m_state = 1;
            default: ;
        endcase
    endtask

    function automatic logic [40:0] exp_vec(input logic [31:0] t);
        return {2'(m_state), m_state == 1 || m_state == 2, m_clr, m_state == 2, 4'(m_lap),
                (m_state == 2) ? m_split : t};
    endfunction

    task automatic drive(input logic r, st, sp, sl, tk, input logic [31:0] t);
        rst = r; start_p = st; stop_p = sp; split_p = sl; tick_ms = tk; time_in = t;
        @(posedge clk);
        model(r, st, sp, sl, tk, t);
        #1;
        rst = 0; start_p = 0; stop_p = 0; split_p = 0; tick_ms = 0;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 32'h1234_5678);
        drive(1, 1, 1, 1, 1, 32'h1234_5678);
        rst = 1; #1;
        total++;
        if ({state, cnt_en, cnt_clr, frozen, lap_cnt} !== 9'd0) begin
            bad++; $display("FAIL reset_state: got %b want 0", {state, cnt_en, cnt_clr, frozen, lap_cnt});
        end
        total++;
        if (disp_time !== 32'h1234_5678) begin
            bad++; $display("FAIL reset_disp: got %h want 12345678", disp_time);
        end
        drive(1, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic test_start();
        drive(0, 1, 0, 0, 0, 32'd0);
        total++;
        if (state !== 2'b01 || cnt_en !== 1'b1 || cnt_clr !== 1'b0) begin
            bad++; $display("FAIL start: state=%b en=%b clr=%b want 01/1/0", state, cnt_en, cnt_clr);
        end
    endtask

    task automatic test_split();
        drive(0, 0, 0, 1, 0, 32'h0001_2345);
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0001_2345 + i);
            total++;
            if (disp_time !== 32'h0001_2345 || frozen !== 1'b1 || lap_cnt !== 4'd1 || state !== 2'b10) begin
                bad++; $display("FAIL split_hold: disp=%h frz=%b lap=%0d st=%b want 00012345/1/1/10",
                                disp_time, frozen, lap_cnt, state);
            end
        end
        drive(0, 0, 0, 1, 0, 32'h0001_2400);
        total++;
        if (disp_time !== 32'h0001_2400 || frozen !== 1'b0 || lap_cnt !== 4'd1 || state !== 2'b01) begin
            bad++; $display("FAIL split_release: disp=%h frz=%b lap=%0d st=%b want 00012400/0/1/01",
                            disp_time, frozen, lap_cnt, state);
        end
    endtask

    task automatic test_stop_split_same();
        drive(0, 0, 1, 1, 0, 32'h0001_2401);
        total++;
        if (state !== 2'b11 || cnt_en !== 1'b0 || lap_cnt !== 4'd1) begin
            bad++; $display("FAIL stop_split: st=%b en=%b lap=%0d want 11/0/1", state, cnt_en, lap_cnt);
        end
    endtask

    task automatic test_clear();
        drive(0, 0, 0, 1, 0, 32'h0001_2401);
        total++;
        if (cnt_clr !== 1'b1 || state !== 2'b00 || lap_cnt !== 4'd0) begin
            bad++; $display("FAIL clear: clr=%b st=%b lap=%0d want 1/00/0", cnt_clr, state, lap_cnt);
        end
        drive(0, 0, 0, 0, 0, 32'd0);
        total++;
        if (cnt_clr !== 1'b0) begin
            bad++; $display("FAIL clear_width: clr=%b want 0", cnt_clr);
        end
        drive(0, 1, 0, 0, 0, 32'd0);
        total++;
        if (state !== 2'b01 || cnt_en !== 1'b1) begin
            bad++; $display("FAIL clear_restart: st=%b en=%b want 01/1", state, cnt_en);
        end
    endtask

    task automatic test_timeout();
        drive(0, 0, 0, 1, 0, 32'h0000_0777);
`ifdef STOPWATCH_SPLIT_TIMEOUT_EN
        for (int i = 1; i < HOLD; i++) begin
            drive(0, 0, 0, 0, 1, 32'd0);
            drive(0, 0, 0, 0, 0, 32'd0);
            total++;
            if (state !== 2'b10) begin
                bad++; $display("FAIL timeout_early: tick %0d st=%b want 10", i, state);
            end
        end
        drive(0, 0, 0, 0, 1, 32'd0);
        total++;
        if (state !== 2'b01 || frozen !== 1'b0 || cnt_en !== 1'b1) begin
            bad++; $display("FAIL timeout_expire: st=%b frz=%b en=%b want 01/0/1", state, frozen, cnt_en);
        end
`else
        for (int i = 1; i <= 100; i++) begin
            drive(0, 0, 0, 0, 1, 32'd0);
            total++;
            if (state !== 2'b10 || disp_time !== 32'h0000_0777) begin
                bad++; $display("FAIL no_timeout: tick %0d st=%b disp=%h want 10/00000777", i, state, disp_time);
            end
        end
        drive(0, 0, 0, 1, 0, 32'd0);
`endif
    endtask

    task automatic test_laps();
        drive(1, 0, 0, 0, 0, 32'd0);
        drive(0, 1, 0, 0, 0, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 0, 1, 0, 32'(i));
            total++;
            if (lap_cnt !== 4'(i % 10) || state !== 2'b10) begin
                bad++; $display("FAIL laps: split %0d lap=%0d st=%b want %0d/10", i, lap_cnt, state, i % 10);
            end
            drive(0, 0, 0, 1, 0, 32'(i));
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 3000; i++) begin
            t = $urandom;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0, t);
            total++;
            if ({state, cnt_en, cnt_clr, frozen, lap_cnt, disp_time} !== exp_vec(t)) begin
                bad++; $display("FAIL random: cycle %0d got %h want %h", i,
                                {state, cnt_en, cnt_clr, frozen, lap_cnt, disp_time}, exp_vec(t));
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_split();
        test_stop_split_same();
        test_clear();
        test_timeout();
        test_laps();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
